program_loader: RTL

Boot-time program loader for the pipelined CPU's shared data/instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them through the memory's write port (memWrite/address/writeData). Holds the CPU in reset until the image is fully written, then releases it. It is the writer on the memory interface that the CPU otherwise only reads, and it replaces `$readmemb` preloading for hardware bring-up.

---
 rtl/program_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : boot loader; length-prefixed byte stream -> 32-bit memory
//                  writes, holds the CPU in reset until the image is written.
// Option macro   : LOADER_CHECKSUM_EN (trailing XOR checksum byte)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [15:0] wordsWritten
);

`ifdef LOADER_CHECKSUM_EN
  localparam logic c_CHECK_EN = 1'b1;
`else
  localparam logic c_CHECK_EN = 1'b0;
`endif

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LEN_HI = 3'd1;
  localparam logic [2:0] c_LEN_LO = 3'd2;
  localparam logic [2:0] c_DATA   = 3'd3;
  localparam logic [2:0] c_WRITE  = 3'd4;
  localparam logic [2:0] c_CHECK  = 3'd5;
  localparam logic [2:0] c_DONE   = 3'd6;
  localparam logic [2:0] c_ERR    = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_byte_ready;
  logic        r_mem_write;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [15:0] r_words;
  logic [15:0] r_len;
  logic [23:0] r_word;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_xor;

  logic        w_accept;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic        w_last;
  logic [2:0]  w_tail;
  logic        w_byte_ready;
  logic        w_mem_write;
  logic        w_cpu_hold;
  logic        w_done;
  logic        w_error;

  assign w_accept = byteValid & r_byte_ready;
  assign w_len    = {r_len[15:8], byteIn};
  assign w_word   = {r_word, byteIn};
  assign w_last   = (r_words + 16'd1) == r_len;
  assign w_tail   = c_CHECK_EN ? c_CHECK : c_DONE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (start) w_next = c_LEN_HI;
      c_LEN_HI: if (w_accept) w_next = c_LEN_LO;
      c_LEN_LO: begin
        if (w_accept) begin
          if (w_len == 16'd0)
            w_next = w_tail;
          else if ({16'd0, w_len} > MAX_WORDS)
            w_next = c_ERR;
          else
            w_next = c_DATA;
        end
      end
      c_DATA:   if (w_accept && (r_byte_cnt == 2'd3)) w_next = c_WRITE;
      c_WRITE:  w_next = w_last ? w_tail : c_DATA;
      c_CHECK:  if (w_accept) w_next = (byteIn == r_xor) ? c_DONE : c_ERR;
      c_DONE,
      c_ERR:    if (start) w_next = c_LEN_HI;
      default:  w_next = c_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    w_byte_ready = (w_next == c_LEN_HI) || (w_next == c_LEN_LO) ||
                   (w_next == c_DATA)   || (w_next == c_CHECK);
    w_mem_write  = (w_next == c_WRITE);
    w_cpu_hold   = (w_next != c_DONE);
    w_done       = (w_next == c_DONE);
    w_error      = (w_next == c_ERR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_write  <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= w_byte_ready;
      r_mem_write  <= w_mem_write;
      r_cpu_hold   <= w_cpu_hold;
      r_done       <= w_done;
      r_error      <= w_error;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_address  <= BASE_ADDR;
      r_wdata    <= 32'd0;
      r_words    <= 16'd0;
      r_len      <= 16'd0;
      r_word     <= 24'd0;
      r_byte_cnt <= 2'd0;
      r_xor      <= 8'd0;
    end else begin
      // Entering LEN_HI only happens from IDLE/DONE/ERR: a fresh load.
      if ((w_next == c_LEN_HI) && (r_state != c_LEN_HI)) begin
        r_words    <= 16'd0;
        r_byte_cnt <= 2'd0;
        r_xor      <= 8'd0;
      end
      if (w_accept) begin
        case (r_state)
          c_LEN_HI: r_len[15:8] <= byteIn;
          c_LEN_LO: r_len[7:0]  <= byteIn;
          c_DATA: begin
            r_word     <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_xor      <= r_xor ^ byteIn;
          end
          default: ;
        endcase
      end
      if ((r_state == c_DATA) && (w_next == c_WRITE)) begin
        r_address <= BASE_ADDR + {14'd0, r_words, 2'b00};
        r_wdata   <= w_word;
      end
      if (r_state == c_WRITE)
        r_words <= r_words + 16'd1;
    end
  end

  assign byteReady    = r_byte_ready;
  assign memWrite     = r_mem_write;
  assign address      = r_address;
  assign writeData    = r_wdata;
  assign cpuHold      = r_cpu_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign wordsWritten = r_words;

endmodule

`default_nettype wire
